// File: rtl/shf_if.sv
// Handshake and operand bundle between the control FSM and the SHF sequencer.
// The tristated bus drive stays a plain port on the sequencer.
interface shf_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] r;
    logic [5:0]       ir_slice;
    logic             en;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       nzp;
    logic [WIDTH-1:0] result;

    modport master (
        output start, r, ir_slice, en,
        input  busy, done, err, nzp, result
    );

    modport slave (
        input  start, r, ir_slice, en,
        output busy, done, err, nzp, result
    );
endinterface

// File: rtl/shf_ctrl.sv
// LC-3b SHF sequencer: one bit position per clock, with a registered result,
// NZP codes and a tristated drive onto the datapath bus.
module shf_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    shf_if.slave             bus,
    output logic [WIDTH-1:0] shf_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] MODE_LSHF  = 2'b00;
    localparam logic [1:0] MODE_ILL   = 2'b10;
    localparam logic [1:0] MODE_RSHFA = 2'b11;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [1:0]       mode_reg, mode_next;
    logic [3:0]       count_reg, count_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [2:0]       nzp_reg, nzp_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] shl, shr, shifted;
    logic             fill;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])   return 3'b100;
        else if (v == '0) return 3'b010;
        else              return 3'b001;
    endfunction

    // Only RSHFA replicates the sign bit; mode 2 never reaches SHIFT.
    assign fill = (mode_reg == MODE_RSHFA) & work_reg[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl[gi] = 1'b0;
            end else begin : g_lmid
                assign shl[gi] = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr[gi] = fill;
            end else begin : g_rmid
                assign shr[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    assign shifted = (mode_reg == MODE_LSHF) ? shl : shr;

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        mode_next   = mode_reg;
        count_next  = count_reg;
        result_next = result_reg;
        nzp_next    = nzp_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    work_next  = bus.r;
                    mode_next  = bus.ir_slice[5:4];
                    count_next = bus.ir_slice[3:0];
                    err_next   = 1'b0;
                    // Illegal mode and zero amount both complete without shifting.
                    if (bus.ir_slice[5:4] == MODE_ILL || bus.ir_slice[3:0] == 4'd0) begin
                        state_next  = DONE;
                        result_next = bus.r;
                        nzp_next    = nzp_of(bus.r);
                        err_next    = (bus.ir_slice[5:4] == MODE_ILL);
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next  = shifted;
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next  = DONE;
                    result_next = shifted;
                    nzp_next    = nzp_of(shifted);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            mode_reg   <= 2'b00;
            count_reg  <= 4'd0;
            result_reg <= '0;
            nzp_reg    <= 3'b010;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            mode_reg   <= mode_next;
            count_reg  <= count_next;
            result_reg <= result_next;
            nzp_reg    <= nzp_next;
            err_reg    <= err_next;
        end
    end

    assign bus.busy   = (state_reg == SHIFT);
    assign bus.done   = (state_reg == DONE);
    assign bus.err    = err_reg;
    assign bus.nzp    = nzp_reg;
    assign bus.result = result_reg;
    assign shf_out    = bus.en ? result_reg : {WIDTH{1'bz}};
endmodule

// File: tb/tb_shf_ctrl.sv
// Directed plus randomized checks of shf_ctrl against an arithmetic shift model.
module tb_shf_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] shf_out;

    shf_if #(.WIDTH(16)) sif ();

    shf_ctrl #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (sif.slave),
        .shf_out (shf_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Architectural state the bench expects the DUT to hold between ops.
    logic [15:0] hold_result = 16'h0000;
    logic [2:0]  hold_nzp    = 3'b010;
    logic        hold_err    = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [2:0] ref_nzp(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    function automatic void ref_op(input logic [15:0] r, input logic [5:0] ir,
                                   output logic [15:0] res, output int k, output logic e);
        int amt;
        amt = int'(ir[3:0]);
        e   = 1'b0;
        k   = amt;
        case (ir[5:4])
            2'd0: res = r << amt;
            2'd1: res = r >> amt;
            2'd3: res = 16'($signed(r) >>> amt);
            default: begin res = r; k = 0; e = 1'b1; end
        endcase
    endfunction

    task automatic launch(input logic [15:0] r, input logic [5:0] ir);
        sif.start    = 1'b1;
        sif.r        = r;
        sif.ir_slice = ir;
    endtask

    // Called at a negedge with the op already presented on start/r/ir_slice.
    task automatic run_op(input logic [15:0] r, input logic [5:0] ir, input bit chain,
                          input logic [15:0] nr, input logic [5:0] nir, input bit poke);
        logic [15:0] exp_res;
        logic        exp_err;
        int          k;
        ref_op(r, ir, exp_res, k, exp_err);
        @(posedge clk);
        for (int c = 1; c <= k + 1; c++) begin
            @(negedge clk);
            if (c == 1) sif.start = 1'b0;
            if (poke && k >= 3 && c == 2) begin
                sif.start = 1'b1;
                sif.r     = 16'($urandom);
            end
            if (poke && c == 3) sif.start = 1'b0;
            chk($sformatf("busy c%0d", c), 16'(sif.busy), 16'(c <= k));
            chk($sformatf("done c%0d", c), 16'(sif.done), 16'(c == k + 1));
            if (c <= k) begin
                chk("result_hold", sif.result, hold_result);
                chk("err_cleared", 16'(sif.err), 16'd0);
            end else begin
                hold_result = exp_res;
                hold_nzp    = ref_nzp(exp_res);
                hold_err    = exp_err;
                chk("result", sif.result, hold_result);
                chk("nzp", 16'(sif.nzp), 16'(hold_nzp));
                chk("err", 16'(sif.err), 16'(hold_err));
                if (sif.en) chk("shf_out", shf_out, hold_result);
                if (chain) launch(nr, nir);
            end
        end
        $display("op r=%h ir=%b k=%0d chain=%0d poke=%0d -> result=%h nzp=%b err=%0d",
                 r, ir, k, chain, poke, sif.result, sif.nzp, sif.err);
        if (!chain) begin
            @(negedge clk);
            chk("done_single", 16'(sif.done), 16'd0);
            chk("idle_busy", 16'(sif.busy), 16'd0);
        end
    endtask

    initial begin
        logic [15:0] cur_r, nr;
        logic [5:0]  cur_ir, nir;
        bit          chain;

        sif.start = 1'b0; sif.r = '0; sif.ir_slice = '0; sif.en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 16'(sif.busy), 16'd0);
        chk("rst_done", 16'(sif.done), 16'd0);
        chk("rst_err", 16'(sif.err), 16'd0);
        chk("rst_result", sif.result, 16'h0000);
        chk("rst_nzp", 16'(sif.nzp), 16'(3'b010));
        sif.en = 1'b1;
        #1 chk("rst_shf_out", shf_out, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        launch(16'h0001, 6'b000100);
        run_op(16'h0001, 6'b000100, 1'b0, '0, '0, 1'b0);
        launch(16'h8000, 6'b111111);
        run_op(16'h8000, 6'b111111, 1'b1, 16'h8000, 6'b011111, 1'b0);
        run_op(16'h8000, 6'b011111, 1'b0, '0, '0, 1'b0);
        launch(16'h0000, 6'b000000);
        run_op(16'h0000, 6'b000000, 1'b0, '0, '0, 1'b0);
        launch(16'h1234, 6'b100011);
        run_op(16'h1234, 6'b100011, 1'b1, 16'h00F0, 6'b010010, 1'b0);
        run_op(16'h00F0, 6'b010010, 1'b0, '0, '0, 1'b0);
        launch(16'h00FF, 6'b000101);
        run_op(16'h00FF, 6'b000101, 1'b0, '0, '0, 1'b1);

        // Reset during cycle 2 of an amount-8 shift.
        launch(16'hABCD, 6'b001000);
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_result = 16'h0000; hold_nzp = 3'b010; hold_err = 1'b0;
        chk("midrst_busy", 16'(sif.busy), 16'd0);
        chk("midrst_result", sif.result, 16'h0000);
        chk("midrst_nzp", 16'(sif.nzp), 16'(3'b010));
        chk("midrst_err", 16'(sif.err), 16'd0);
        begin
            bit seen_done = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (sif.done) seen_done = 1'b1;
            end
            chk("midrst_no_done", 16'(seen_done), 16'd0);
        end
        $display("mid-op reset: result=%h nzp=%b", sif.result, sif.nzp);

        cur_r  = 16'($urandom);
        cur_ir = 6'($urandom);
        sif.en = 1'($urandom);
        launch(cur_r, cur_ir);
        for (int i = 0; i < 30; i++) begin
            nr    = 16'($urandom);
            nir   = 6'($urandom);
            chain = (i < 29) ? 1'($urandom) : 1'b0;
            run_op(cur_r, cur_ir, chain, nr, nir, 1'($urandom));
            if (i < 29 && !chain) begin
                sif.en = 1'($urandom);
                launch(nr, nir);
            end
            cur_r  = nr;
            cur_ir = nir;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
